// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Fetch-side controller for the PC register. Takes the current PC, fetches
//   one instruction at a time from instruction memory over a valid/ready
//   request plus a separate response strobe, holds the instruction for
//   decode, and produces the PC-register controls (EN, NextPC, Jump,
//   Instr[25:0]) when decode takes it.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   pc              current PC from the PC register
//   imem_req/addr   fetch request valid / fetch address (= pc)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response strobe, imem_rdata carries the instruction
//   stall           decode cannot take the held instruction
//   flush           PC redirected; discard any current or in-flight fetch
//   instr           registered instruction to decode
//   instr_valid     instr holds a valid instruction
//   pc_en           one-cycle PC-register enable per retired fetch
//   next_pc         pc + 4, wrapping modulo 2^32
//   jump            PC-register Jump, only ever high together with pc_en
//   jump_target     instr[25:0]
//   fetch_err       sticky flag: memory response timed out
//
// Handshake: a request transfers on a cycle where imem_req && imem_ready.
// imem_req, once raised, stays high with imem_addr stable until accepted,
// unless flush withdraws it. Exactly one response (imem_rvalid) is expected
// per accepted request; a response seen outside WAIT is ignored.

module instr_fetch_ctrl #(
  parameter int          TIMEOUT  = 16,
  parameter logic [5:0]  J_OPCODE = 6'b000010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        pc_en,
  output logic [31:0] next_pc,
  output logic        jump,
  output logic [25:0] jump_target,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            retire;

  // Decode takes the held instruction: only in HOLD, not stalled, not flushed.
  assign retire = (state_q == S_HOLD) && !stall && !flush;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = !flush;
      end

      S_REQ: begin
        if (req_q && imem_ready) begin
          // Accepted even under flush; the response is then dropped.
          state_d = S_WAIT;
          req_d   = 1'b0;
          cnt_d   = '0;
          drop_d  = flush;
        end else begin
          // A flush withdraws the request for one cycle so the re-issue
          // carries the redirected pc.
          req_d = !flush;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (drop_q || flush) begin
            state_d = S_REQ;
            req_d   = !flush;
          end else begin
            state_d = S_HOLD;
            instr_d = imem_rdata;
            valid_d = 1'b1;
          end
        end else begin
          if (flush) begin
            drop_d = 1'b1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            drop_d  = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (flush || !stall) begin
          state_d = S_REQ;
          valid_d = 1'b0;
          req_d   = !flush;
        end
      end

      S_ERR: begin
        // Terminal until reset: no requests, error stays set.
        req_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;
  assign pc_en       = retire;
  assign jump        = retire && (instr_q[31:26] == J_OPCODE);
  assign next_pc     = pc + 32'd4;
  assign jump_target = instr_q[25:0];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl. A transaction-level model tracks what
// the fetch unit must be doing (waiting to request, request outstanding,
// instruction held, errored) and a compare process checks every output on
// every falling edge. The driver walks through the directed scenarios and
// adds hand-computed literal checks at the interesting cycles. The bench
// also plays the PC register: on pc_en it loads next_pc, or the jump target
// when jump is set.

module tb_instr_fetch_ctrl;

  localparam int         TIMEOUT  = 16;
  localparam logic [5:0] J_OPCODE = 6'b000010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        pc_en;
  logic [31:0] next_pc;
  logic        jump;
  logic [25:0] jump_target;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  instr_fetch_ctrl #(.TIMEOUT(TIMEOUT), .J_OPCODE(J_OPCODE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_en       (pc_en),
    .next_pc     (next_pc),
    .jump        (jump),
    .jump_target (jump_target),
    .fetch_err   (fetch_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Transaction-level model of the fetch unit.
  bit          m_started = 0;   // first post-reset cycle has gone by
  bit          m_req = 0;       // a request should be visible
  bit          m_busy = 0;      // request accepted, response owed
  int          m_cnt = 0;       // cycles spent waiting for the response
  bit          m_discard = 0;   // owed response must be thrown away
  bit          m_have = 0;      // an instruction is held for decode
  logic [31:0] m_instr = 32'h0;
  bit          m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 0; m_req = 0; m_busy = 0; m_cnt = 0;
      m_discard = 0; m_have = 0; m_instr = 32'h0; m_err = 0;
    end else if (!m_err) begin
      if (!m_started) begin
        m_started = 1;
        m_req = !flush;
      end else if (m_have) begin
        if (flush || !stall) begin
          m_have = 0;
          m_req = !flush;
        end
      end else if (m_busy) begin
        if (imem_rvalid) begin
          m_busy = 0;
          if (m_discard || flush) m_req = !flush;
          else begin
            m_instr = imem_rdata;
            m_have = 1;
          end
          m_discard = 0;
        end else begin
          m_cnt++;
          if (flush) m_discard = 1;
          if (m_cnt >= TIMEOUT) begin
            m_err = 1;
            m_busy = 0;
          end
        end
      end else if (m_req && imem_ready) begin
        m_busy = 1;
        m_cnt = 0;
        m_discard = flush;
        m_req = 0;
      end else begin
        m_req = !flush;
      end
    end
  end

  // scoreboard compare: every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_en, exp_jump;
      exp_en   = m_have && !stall && !flush;
      exp_jump = exp_en && (m_instr[31:26] == J_OPCODE);
      chk("cmp_imem_req", imem_req, m_req);
      if (m_req) chk("cmp_imem_addr", imem_addr, pc);
      chk("cmp_instr", instr, m_instr);
      chk("cmp_instr_valid", instr_valid, m_have);
      chk("cmp_pc_en", pc_en, exp_en);
      chk("cmp_jump", jump, exp_jump);
      chk("cmp_next_pc", next_pc, pc + 32'd4);
      chk("cmp_jump_target", 32'(jump_target), 32'(m_instr[25:0]));
      chk("cmp_fetch_err", fetch_err, m_err);
    end
  end

  // driver tasks: inputs change only at posedge+1; checks happen at negedge
  logic        pc_fire;
  logic [31:0] pc_load;

  task automatic nedge();
    @(negedge clk);
  endtask

  // Also acts as the PC register: loads on pc_en, jump has priority.
  task automatic pedge();
    pc_fire = pc_en;
    pc_load = jump ? {next_pc[31:28], jump_target, 2'b00} : next_pc;
    @(posedge clk);
    #1;
    if (pc_fire === 1'b1) pc = pc_load;
  endtask

  task automatic cycle();
    nedge();
    pedge();
  endtask

  // Wait for a visible request with ready high; returns at first WAIT cycle.
  task automatic accept();
    int n;
    n = 0;
    imem_ready = 1'b1;
    nedge();
    while (imem_req !== 1'b1 && n < 40) begin
      pedge();
      nedge();
      n++;
    end
    chk("req_wait", imem_req, 1'b1);
    pedge();
    imem_ready = 1'b0;
  endtask

  // Full fetch: accept, response lat cycles later; returns at first HOLD cycle.
  task automatic issue_fetch(input logic [31:0] data, input int lat);
    accept();
    repeat (lat - 1) cycle();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    cycle();
    imem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    chk_en = 1'b1;
    nedge();
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_pc_en", pc_en, 1'b0);
    chk("rst_fetch_err", fetch_err, 1'b0);
    pedge();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    #1;
    do_reset();

    // Plain fetch from pc=0, response one cycle after acceptance.
    issue_fetch(32'h2000_0010, 1);
    nedge();
    chk("t1_instr_valid", instr_valid, 1'b1);
    chk("t1_instr", instr, 32'h2000_0010);
    chk("t1_pc_en", pc_en, 1'b1);
    chk("t1_next_pc", next_pc, 32'h0000_0004);
    chk("t1_jump", jump, 1'b0);
    pedge();
    nedge();
    chk("t1_valid_clr", instr_valid, 1'b0);
    chk("t1_req_again", imem_req, 1'b1);
    chk("t1_addr", imem_addr, 32'h0000_0004);
    pedge();

    // Absolute jump opcode.
    issue_fetch(32'h0800_0040, 2);
    nedge();
    chk("t2_pc_en", pc_en, 1'b1);
    chk("t2_jump", jump, 1'b1);
    chk("t2_target", 32'(jump_target), 32'h0000_0040);
    pedge();
    nedge();
    chk("t2_addr", imem_addr, 32'h0000_0100);
    pedge();

    // Stall held three cycles in HOLD, then exactly one retire pulse.
    stall = 1'b1;
    issue_fetch(32'h1234_5678, 1);
    for (int i = 0; i < 3; i++) begin
      nedge();
      chk("t3_stall_pc_en", pc_en, 1'b0);
      chk("t3_stall_valid", instr_valid, 1'b1);
      chk("t3_stall_instr", instr, 32'h1234_5678);
      pedge();
    end
    stall = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      nedge();
      if (pc_en === 1'b1) pulses++;
      pedge();
    end
    chk("t3_pulses", pulses, 1);
    chk("t3_pc", pc, 32'h0000_0104);

    // Flush in REQ withdraws the request one cycle; stray rvalid ignored.
    flush = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    nedge();
    chk("t4_req_hold", imem_req, 1'b1);
    pedge();
    flush = 1'b0;
    imem_rvalid = 1'b0;
    nedge();
    chk("t4_req_drop", imem_req, 1'b0);
    pedge();
    nedge();
    chk("t4_req_back", imem_req, 1'b1);
    chk("t4_instr", instr, 32'h1234_5678);
    pedge();

    // Flush while waiting: response discarded, fresh request follows.
    accept();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cycle();
    imem_rvalid = 1'b0;
    nedge();
    chk("t5_instr", instr, 32'h1234_5678);
    chk("t5_valid", instr_valid, 1'b0);
    chk("t5_req", imem_req, 1'b1);
    chk("t5_addr", imem_addr, 32'h0000_0104);
    pedge();

    // Flush on the acceptance cycle: accepted, response dropped.
    imem_ready = 1'b1;
    flush = 1'b1;
    nedge();
    pedge();
    imem_ready = 1'b0;
    flush = 1'b0;
    nedge();
    chk("t6_req_off", imem_req, 1'b0);
    pedge();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    cycle();
    imem_rvalid = 1'b0;
    nedge();
    chk("t6_valid", instr_valid, 1'b0);
    chk("t6_instr", instr, 32'h1234_5678);
    chk("t6_req", imem_req, 1'b1);
    pedge();

    // Flush in HOLD overrides stall: no retire, back to requesting.
    stall = 1'b1;
    issue_fetch(32'h0000_1111, 1);
    flush = 1'b1;
    nedge();
    chk("t7_pc_en", pc_en, 1'b0);
    chk("t7_valid", instr_valid, 1'b1);
    pedge();
    flush = 1'b0;
    stall = 1'b0;
    nedge();
    chk("t7_valid_clr", instr_valid, 1'b0);
    chk("t7_req_off", imem_req, 1'b0);
    pedge();
    nedge();
    chk("t7_req_on", imem_req, 1'b1);
    pedge();

    // PC wrap at the top of the address space.
    pc = 32'hFFFF_FFFC;
    nedge();
    chk("t8_next_pc", next_pc, 32'h0000_0000);
    chk("t8_addr", imem_addr, 32'hFFFF_FFFC);
    pedge();
    issue_fetch(32'h2000_0000, 1);
    nedge();
    chk("t8_pc_en", pc_en, 1'b1);
    pedge();
    nedge();
    chk("t8_wrap_addr", imem_addr, 32'h0000_0000);
    pedge();

    // Timeout: no response for TIMEOUT cycles -> sticky error, no requests.
    accept();
    for (int i = 1; i <= TIMEOUT; i++) begin
      nedge();
      if (i == TIMEOUT) chk("t9_err_before", fetch_err, 1'b0);
      pedge();
    end
    nedge();
    chk("t9_err", fetch_err, 1'b1);
    pedge();
    imem_ready = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      nedge();
      chk("t9_req_stopped", imem_req, 1'b0);
      chk("t9_err_sticky", fetch_err, 1'b1);
      pedge();
    end
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;

    // Reset mid-WAIT, with a late response arriving around release.
    do_reset();
    accept();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("t10_req", imem_req, 1'b0);
    chk("t10_instr", instr, 32'h0);
    chk("t10_valid", instr_valid, 1'b0);
    chk("t10_pc_en", pc_en, 1'b0);
    chk("t10_jump", jump, 1'b0);
    chk("t10_err", fetch_err, 1'b0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    imem_rvalid = 1'b0;
    nedge();
    chk("t10_late_valid", instr_valid, 1'b0);
    chk("t10_late_instr", instr, 32'h0);
    pedge();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
